act_lut_loader: RTL and testbench

Writer side of the activation-function lookup table used by each layer's `func` block. It accepts a streamed set of signed 8-bit samples over a valid/ready handshake and stores them in a register-file table. It then serves the `base`/`next_data` pair for a 4-bit address, so the existing LUT+interpolator path can switch from a hard-wired table to a runtime-programmable one. One instance sits beside each activation function, between the weight/config loader and the interpolator.

---
 rtl/nn_act_pkg.sv | 18 +
 rtl/act_lut_loader_if.sv | 34 +++
 rtl/act_lut_regfile.sv | 41 ++++
 rtl/act_lut_loader.sv | 125 ++++++++++++
 tb/tb_act_lut_loader.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_act_pkg.sv
// Shared types and sizes for the activation-function LUT path.
// The checksum feature is enabled by defining ACT_LUT_CHECKSUM_EN.
package nn_act_pkg;

    localparam int ACT_DATA_W  = 8;
    localparam int ACT_ADDR_W  = 4;
    localparam int ACT_ENTRIES = 16;

    typedef logic signed [ACT_DATA_W-1:0] act_sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE
    } act_load_state_t;

endpackage

// File: rtl/act_lut_loader_if.sv
// Load handshake and lookup bus between the config loader,
// the LUT writer and the interpolator.
interface act_lut_loader_if
    import nn_act_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int ADDR_W = ACT_ADDR_W
);

    logic                     load_start;
    logic                     load_valid;
    logic signed [DATA_W-1:0] load_data;
    logic                     load_ready;
    logic                     load_done;
    logic                     load_error;
    logic                     busy;
    logic                     table_valid;
    logic        [ADDR_W-1:0] address;
    logic signed [DATA_W-1:0] base;
    logic signed [DATA_W-1:0] next_data;

    modport master (
        output load_start, load_valid, load_data, address,
        input  load_ready, load_done, load_error, busy,
        input  table_valid, base, next_data
    );

    modport slave (
        input  load_start, load_valid, load_data, address,
        output load_ready, load_done, load_error, busy,
        output table_valid, base, next_data
    );

endinterface

// File: rtl/act_lut_regfile.sv
// ENTRIES+1 sample register file: one write port and a combinational
// read pair at (addr, addr+1) for segment interpolation.
module act_lut_regfile
    import nn_act_pkg::*;
#(
    parameter int ENTRIES = ACT_ENTRIES,
    parameter int DATA_W  = ACT_DATA_W,
    parameter int ADDR_W  = $clog2(ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic        [ADDR_W:0]   i_waddr,
    input  logic signed [DATA_W-1:0] i_wdata,
    input  logic        [ADDR_W-1:0] i_raddr,
    output logic signed [DATA_W-1:0] o_rdata0,
    output logic signed [DATA_W-1:0] o_rdata1
);

    logic signed [DATA_W-1:0] r_mem [0:ENTRIES];
    logic        [ADDR_W:0]   w_ra0;
    logic        [ADDR_W:0]   w_ra1;

    // Extra top entry keeps addr+1 in range, so no wrap is needed.
    assign w_ra0 = {1'b0, i_raddr};
    assign w_ra1 = w_ra0 + (ADDR_W+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[w_ra0];
    assign o_rdata1 = r_mem[w_ra1];

endmodule

// File: rtl/act_lut_loader.sv
// Runtime loader for the activation LUT; define ACT_LUT_CHECKSUM_EN
// to require a trailing checksum beat that must bring the sum to zero.
module act_lut_loader
    import nn_act_pkg::*;
#(
    parameter int ENTRIES = ACT_ENTRIES,
    parameter int DATA_W  = ACT_DATA_W
) (
    input logic              clk,
    input logic              rst,
    act_lut_loader_if.slave  bus
);

    localparam int AW = $clog2(ENTRIES);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] LAST = PW'(ENTRIES);

    act_load_state_t r_state;
    act_load_state_t w_next;
    logic [PW-1:0]   r_wptr;
    logic            r_table_valid;
    logic            w_ready;
    logic            w_beat;
    logic            w_start;
    logic            w_last;
    logic            w_set_valid;
    logic            w_we;

    assign w_ready = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign w_beat  = bus.load_valid & w_ready;
    assign w_start = (r_state == ST_IDLE) & bus.load_start;
    assign w_we    = w_beat & (r_state == ST_LOAD);
    assign w_last  = w_we & (r_wptr == LAST);

`ifdef ACT_LUT_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic [DATA_W-1:0] w_sum;
    logic              r_error;

    assign w_sum = r_sum + bus.load_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= '0;
            r_error <= 1'b0;
        end else if (w_start) begin
            r_sum   <= '0;
            r_error <= 1'b0;
        end else if (w_beat) begin
            r_sum <= w_sum;
            if (r_state == ST_CHECK) begin
                r_error <= (w_sum != '0);
            end
        end
    end

    assign bus.load_error = (r_state == ST_DONE) & r_error;
    assign w_set_valid = w_beat & (r_state == ST_CHECK) & (w_sum == '0);
`else
    assign bus.load_error = 1'b0;
    assign w_set_valid = w_last;
`endif

    always_comb begin
        w_next        = r_state;
        bus.load_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.load_start) w_next = ST_LOAD;
            end
            ST_LOAD: begin
`ifdef ACT_LUT_CHECKSUM_EN
                if (w_last) w_next = ST_CHECK;
`else
                if (w_last) w_next = ST_DONE;
`endif
            end
            ST_CHECK: begin
                if (w_beat) w_next = ST_DONE;
            end
            ST_DONE: begin
                bus.load_done = 1'b1;
                w_next        = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_wptr        <= '0;
            r_table_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_wptr        <= '0;
                r_table_valid <= 1'b0;
            end else begin
                if (w_we) r_wptr <= r_wptr + PW'(1);
                if (w_set_valid) r_table_valid <= 1'b1;
            end
        end
    end

    assign bus.load_ready  = w_ready;
    assign bus.busy        = w_ready;
    assign bus.table_valid = r_table_valid;

    act_lut_regfile #(
        .ENTRIES (ENTRIES),
        .DATA_W  (DATA_W),
        .ADDR_W  (AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (r_wptr),
        .i_wdata  (bus.load_data),
        .i_raddr  (bus.address),
        .o_rdata0 (bus.base),
        .o_rdata1 (bus.next_data)
    );

endmodule

// File: tb/tb_act_lut_loader.sv
// Randomized self-checking bench for act_lut_loader against an
// array-based table model; honours ACT_LUT_CHECKSUM_EN.
module tb_act_lut_loader;
    import nn_act_pkg::*;

`ifdef ACT_LUT_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    localparam int NS = ACT_ENTRIES + 1;
    localparam int NB = NS + (CK ? 1 : 0);

    logic clk = 1'b0;
    logic rst;

    act_lut_loader_if bus ();

    act_lut_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int model [0:NS-1];
    bit model_valid;
    int stim  [0:NS];

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_table(input string tag);
        for (int a = 0; a < ACT_ENTRIES; a++) begin
            @(negedge clk);
            bus.address = 4'(a);
            #1;
            check({tag, "_base"}, int'(bus.base), model[a]);
            check({tag, "_next"}, int'(bus.next_data), model[a+1]);
        end
        check({tag, "_tv"}, bus.table_valid, model_valid);
        tick();
    endtask

    task automatic fill_random();
        int sum;
        sum = 0;
        for (int i = 0; i < NS; i++) begin
            stim[i] = int'($urandom_range(255)) - 128;
            sum += stim[i];
        end
        stim[NS] = (-sum) & 255;
    endtask

    // mode: 0 no gaps, 1 alternate cycles, 2 random gaps
    task automatic run_load(input int mode, input int start_at,
                            input bit start_in_done, input int rst_at);
        int acc;
        int gaps;
        int cyc;
        int sum;
        bit v;
        bit exp_err;
        acc  = 0;
        gaps = 0;
        cyc  = 0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check("start_ready", bus.load_ready, 1);
        check("start_busy", bus.busy, 1);
        check("start_tv", bus.table_valid, 0);
        model_valid = 1'b0;
        while (acc < NB) begin
            if (cyc > 2000) begin
                check("load_timeout", cyc, 0);
                break;
            end
            case (mode)
                1:       v = (cyc % 2 == 0);
                2:       v = ($urandom_range(99) >= 35);
                default: v = 1'b1;
            endcase
            bus.load_valid = v;
            bus.load_data  = 8'(stim[acc]);
            bus.load_start = (start_at == acc);
            check("ld_ready", bus.load_ready, 1);
            check("ld_done", bus.load_done, 0);
            tick();
            cyc++;
            if (!v) begin
                gaps++;
                continue;
            end
            if (acc < NS) begin
                model[acc] = stim[acc];
                bus.address = (acc < ACT_ENTRIES) ? 4'(acc) : 4'(ACT_ENTRIES-1);
                #1;
                if (acc < ACT_ENTRIES)
                    check("wr_vis", int'(bus.base), stim[acc]);
                else
                    check("wr_vis_top", int'(bus.next_data), stim[acc]);
            end
            acc++;
            if (rst_at > 0 && acc == rst_at) begin
                bus.load_valid = 1'b0;
                bus.load_start = 1'b0;
                rst = 1'b1;
                #1;
                for (int i = 0; i < NS; i++) model[i] = 0;
                model_valid = 1'b0;
                check("rst_ready", bus.load_ready, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_done", bus.load_done, 0);
                check("rst_err", bus.load_error, 0);
                check("rst_tv", bus.table_valid, 0);
                check("rst_base", int'(bus.base), 0);
                check("rst_next", int'(bus.next_data), 0);
                rst = 1'b0;
                tick();
                return;
            end
        end
        bus.load_valid = 1'b0;
        bus.load_start = start_in_done;
        sum = 0;
        for (int i = 0; i <= NS; i++) sum += stim[i];
        exp_err = CK && ((sum & 255) != 0);
        check("done_pulse", bus.load_done, 1);
        check("done_busy", bus.busy, 0);
        check("done_ready", bus.load_ready, 0);
        check("done_err", bus.load_error, exp_err);
        check("done_tv", bus.table_valid, !exp_err);
        check("done_cycles", cyc, NB + gaps);
        if (mode == 1) check("alt_gaps", gaps, NB - 1);
        model_valid = !exp_err;
        tick();
        bus.load_start = 1'b0;
        check("post_done", bus.load_done, 0);
        check("post_busy", bus.busy, 0);
        check("post_err", bus.load_error, 0);
        check("post_tv", bus.table_valid, model_valid);
        tick();
        check("post2_busy", bus.busy, 0);
    endtask

    initial begin
        int sum;
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.address    = 4'd7;
        for (int i = 0; i < NS; i++) model[i] = 0;
        model_valid = 1'b0;
        #12;
        check("rst_ready0", bus.load_ready, 0);
        check("rst_busy0", bus.busy, 0);
        check("rst_done0", bus.load_done, 0);
        check("rst_err0", bus.load_error, 0);
        check("rst_tv0", bus.table_valid, 0);
        rst = 1'b0;
        tick();
        check_table("reset");

        // Ramp -8..8, no stalls
        sum = 0;
        for (int i = 0; i < NS; i++) begin
            stim[i] = i - 8;
            sum += stim[i];
        end
        stim[NS] = (-sum) & 255;
        run_load(0, -1, 1'b0, 0);
        check_table("ramp");
        @(negedge clk);
        bus.address = 4'd3;
        #1;
        check("ramp_a3_base", int'(bus.base), -5);
        check("ramp_a3_next", int'(bus.next_data), -4);

        // Same ramp with alternate-cycle gaps (also a reload over valid)
        run_load(1, -1, 1'b0, 0);
        check_table("ramp_gap");

        // Abort mid-load, then a fresh load
        fill_random();
        run_load(0, -1, 1'b0, 9);
        check_table("aborted");
        fill_random();
        run_load(2, -1, 1'b0, 0);
        check_table("fresh");
        @(negedge clk);
        bus.address = 4'd15;
        #1;
        check("fresh_a15_next", int'(bus.next_data), model[16]);

        // load_start at beat 5 and in the DONE cycle are ignored
        fill_random();
        run_load(0, 5, 1'b1, 0);
        check_table("start_ign");
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_busy", bus.busy, 0);
            check("idle_ready", bus.load_ready, 0);
        end

`ifdef ACT_LUT_CHECKSUM_EN
        fill_random();
        stim[NS] = (stim[NS] + 1) & 255;
        run_load(0, -1, 1'b0, 0);
        check_table("bad_ck");
`endif

        // Random reloads over a valid table
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_load(2, -1, 1'b0, 0);
            check_table("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
